// File: rtl/mul_link_host.sv
// Host end of the multiplier test link: streams {A, B[15:8], B[7:0]} to the DUT and
// reassembles the 24-bit product from the DUT's rotating output-byte slots.
module mul_link_host #(
    parameter bit         CHECK_SUM = 1'b1,
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [7:0]  req_a_i,
    input  logic [15:0] req_b_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [23:0] res_product_o,
    output logic        res_sum_err_o,
    output logic [7:0]  link_out_o,
    input  logic [7:0]  link_in_i,
    input  logic [7:0]  link_sum_i
);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  word_ref_q, word_ref_d;
    logic [1:0]  frame_q, frame_d;
    logic        primed_q, primed_d;
    logic [2:0]  got_q, got_d;
    logic        err_q, err_d;
    logic [7:0]  link_out_q, link_out_d;
    logic [7:0]  a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [23:0] product_q, product_d;

    logic [1:0]  frame_next;
    logic [7:0]  next_byte;
    logic [7:0]  exp_sum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            word_ref_q <= 2'd0;
            frame_q    <= 2'd0;
            primed_q   <= 1'b0;
            got_q      <= 3'b000;
            err_q      <= 1'b0;
            link_out_q <= IDLE_BYTE;
            a_q        <= 8'h00;
            b_q        <= 16'h0000;
            product_q  <= 24'h000000;
        end else begin
            state_q    <= state_d;
            word_ref_q <= word_ref_d;
            frame_q    <= frame_d;
            primed_q   <= primed_d;
            got_q      <= got_d;
            err_q      <= err_d;
            link_out_q <= link_out_d;
            a_q        <= a_d;
            b_q        <= b_d;
            product_q  <= product_d;
        end
    end

    assign frame_next = (frame_q == 2'd2) ? 2'd0 : frame_q + 2'd1;
    assign exp_sum    = a_q + b_q[7:0];

    always_comb begin
        case (frame_next)
            2'd0:    next_byte = a_q;
            2'd1:    next_byte = b_q[15:8];
            default: next_byte = b_q[7:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        word_ref_d = word_ref_q + 2'd1;
        frame_d    = frame_q;
        primed_d   = primed_q;
        got_d      = got_q;
        err_d      = err_q;
        link_out_d = IDLE_BYTE;
        a_d        = a_q;
        b_d        = b_q;
        product_d  = product_q;

        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    a_d        = req_a_i;
                    b_d        = req_b_i;
                    link_out_d = req_a_i;
                    frame_d    = 2'd0;
                    primed_d   = 1'b0;
                    got_d      = 3'b000;
                    err_d      = 1'b0;
                    product_d  = 24'h000000;
                    state_d    = StStream;
                end
            end
            StStream: begin
                frame_d    = frame_next;
                link_out_d = next_byte;
                primed_d   = primed_q | (frame_q == 2'd2);
                // Aligned cycle: DUT shift register holds {A, Bhi, Blo}.
                if (primed_q && frame_q == 2'd0) begin
                    case (word_ref_q)
                        2'd0: if (!got_q[0]) begin product_d[7:0]   = link_in_i; got_d[0] = 1'b1; end
                        2'd1: if (!got_q[1]) begin product_d[15:8]  = link_in_i; got_d[1] = 1'b1; end
                        2'd2: if (!got_q[2]) begin product_d[23:16] = link_in_i; got_d[2] = 1'b1; end
                        default: ;
                    endcase
                    if (CHECK_SUM && link_sum_i != exp_sum) err_d = 1'b1;
                end
                if (got_d == 3'b111) begin
                    state_d    = StDone;
                    link_out_d = IDLE_BYTE;
                end
            end
            StDone: begin
                if (res_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready_o   = (state_q == StIdle);
    assign res_valid_o   = (state_q == StDone);
    assign res_product_o = product_q;
    assign res_sum_err_o = CHECK_SUM ? err_q : 1'b0;
    assign link_out_o    = link_out_q;

endmodule

// File: tb/tb_mul_link_host.sv
// Bench for mul_link_host: behavioural multiplier DUT on the link, directed requests,
// expected results queued at issue and checked by a monitor on each result handshake.
module tb_mul_link_host;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, res_valid, res_ready, res_sum_err;
    logic [7:0]  req_a, link_out, link_in, link_sum;
    logic [15:0] req_b;
    logic [23:0] res_product;
    logic        sum_bad;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [23:0] p;
        logic        e;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mul_link_host #(.CHECK_SUM(1'b1), .IDLE_BYTE(8'h00)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .res_product_o (res_product),
        .res_sum_err_o (res_sum_err),
        .link_out_o    (link_out),
        .link_in_i     (link_in),
        .link_sum_i    (link_sum)
    );

    // Behavioural multiplier DUT: 3-byte shift register plus free-running slot counter.
    logic [7:0]  sr2, sr1, sr0;
    logic [1:0]  slot;
    logic [23:0] prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr2 <= 8'h00; sr1 <= 8'h00; sr0 <= 8'h00; slot <= 2'd0;
        end else begin
            sr2 <= sr1; sr1 <= sr0; sr0 <= link_out; slot <= slot + 2'd1;
        end
    end

    always_comb begin
        prod = {16'h0000, sr2} * {8'h00, sr1, sr0};
        case (slot)
            2'd0:    link_in = prod[7:0];
            2'd1:    link_in = prod[15:8];
            2'd2:    link_in = prod[23:16];
            default: link_in = 8'hA5;
        endcase
        link_sum = (sr2 + sr0) ^ (sum_bad ? 8'hFF : 8'h00);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_product", {8'h00, res_product}, {8'h00, e.p});
                chk("res_sum_err", {31'd0, res_sum_err}, {31'd0, e.e});
            end
        end
    end

    task automatic do_req(input logic [7:0] a, input logic [15:0] b, input logic [23:0] p,
                          input logic e, input bit seq, input bit corrupt, input int hold);
        int cyc;
        logic [7:0] s [3];
        s[0] = a; s[1] = b[15:8]; s[2] = b[7:0];
        exp_q.push_back({p, e});
        @(negedge clk);
        chk("req_ready idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 0;
        while (!res_valid && cyc < 15) begin
            if (seq && cyc < 9) chk("link_out seq", {24'd0, link_out}, {24'd0, s[cyc % 3]});
            if (corrupt) sum_bad = (cyc == 3);
            @(posedge clk); #1;
            cyc++;
        end
        sum_bad = 1'b0;
        chk("res_valid latency", {31'd0, res_valid}, 32'd1);
        if (hold > 0) begin
            req_valid = 1'b1; req_a = 8'h55; req_b = 16'h1111;
            for (int i = 0; i < hold; i++) begin
                chk("hold res_valid", {31'd0, res_valid}, 32'd1);
                chk("hold res_product", {8'h00, res_product}, {8'h00, p});
                chk("hold req_ready", {31'd0, req_ready}, 32'd0);
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("res_valid cleared", {31'd0, res_valid}, 32'd0);
        chk("req_ready back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
        req_a = 8'h00; req_b = 16'h0000; sum_bad = 1'b0;
        #1;
        chk("reset link_out", {24'd0, link_out}, 32'h00);
        chk("reset res_valid", {31'd0, res_valid}, 32'd0);
        chk("reset res_product", {8'h00, res_product}, 32'h0);
        chk("reset res_sum_err", {31'd0, res_sum_err}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("req_ready after reset", {31'd0, req_ready}, 32'd1);

        do_req(8'h03, 16'h0102, 24'h000306, 1'b0, 1'b1, 1'b0, 0);
        do_req(8'hFF, 16'hFFFF, 24'hFEFF01, 1'b0, 1'b1, 1'b0, 0);

        // Vary idle gap so requests start at each word_ref phase.
        repeat (0) @(posedge clk);
        do_req(8'h12, 16'h0034, 24'h0003A8, 1'b0, 1'b0, 1'b0, 0);
        repeat (1) @(posedge clk);
        do_req(8'h07, 16'h1234, 24'h007F6C, 1'b0, 1'b0, 1'b0, 0);
        repeat (2) @(posedge clk);
        do_req(8'hAB, 16'hCDEF, 24'h898EA5, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        do_req(8'h80, 16'h8001, 24'h400080, 1'b0, 1'b0, 1'b0, 0);

        do_req(8'h05, 16'h0007, 24'h000023, 1'b0, 1'b0, 1'b0, 20);
        do_req(8'h10, 16'h0020, 24'h000200, 1'b1, 1'b0, 1'b1, 0);

        // Reset in the middle of a stream aborts without a result.
        @(negedge clk);
        req_valid = 1'b1; req_a = 8'h21; req_b = 16'h4321;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort link_out", {24'd0, link_out}, 32'h00);
        chk("abort res_valid", {31'd0, res_valid}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        do_req(8'h03, 16'h0102, 24'h000306, 1'b0, 1'b1, 1'b0, 0);

        repeat (2) @(posedge clk);
        chk("queue drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
